// File: rtl/pe_pkg.sv
// Shared types and sizing helpers for the convolution PE control path.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE, CONFIG, WAIT, COMPUTE, DRAIN, ADV_FILTER, ADV_ROW, FINISH
  } state_e;

  localparam int PIPE_DEPTH_DEF    = 3;
  localparam int ROW_CNT_WIDTH_DEF = 8;

  // drain counter must hold PIPE_DEPTH-1
  function automatic int drain_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DRAIN_W = drain_w(PIPE_DEPTH_DEF);

endpackage

// File: rtl/pe_sequencer_if.sv
// Control/status bundle between the PE sequencer and its datapath/host.
interface pe_sequencer_if #(parameter int ROW_CNT_WIDTH = 8);
  logic                     start;
  logic [ROW_CNT_WIDTH-1:0] num_rows;
  logic av_data, av_filter, co_filter, end_of_row, end_of_filter, psum_full;
  logic ld_stride, ld_fileSize, put_data, put_filter, clear_sum;
  logic store_buffer, next_filter, next_row, busy, done;

  modport master (
    input  start, num_rows, av_data, av_filter, co_filter, end_of_row,
           end_of_filter, psum_full,
    output ld_stride, ld_fileSize, put_data, put_filter, clear_sum,
           store_buffer, next_filter, next_row, busy, done
  );

  modport slave (
    output start, num_rows, av_data, av_filter, co_filter, end_of_row,
           end_of_filter, psum_full,
    input  ld_stride, ld_fileSize, put_data, put_filter, clear_sum,
           store_buffer, next_filter, next_row, busy, done
  );
endinterface

// File: rtl/pe_sequencer.sv
// Job-level control FSM for the PE: config, window issue with stalls,
// MAC pipeline drain, then filter/row advance until all rows are done.
module pe_sequencer
  import pe_pkg::*;
#(
  parameter int PIPE_DEPTH    = PIPE_DEPTH_DEF,
  parameter int ROW_CNT_WIDTH = ROW_CNT_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  pe_sequencer_if.master io
);

  localparam int DW = drain_w(PIPE_DEPTH);

  state_e                   state_q, state_d;
  logic [ROW_CNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [ROW_CNT_WIDTH-1:0] rows_q, rows_d;
  logic [DW-1:0]            drain_q, drain_d;
  logic                     eor_q, eor_d, eof_q, eof_d;
  logic                     go, put;
  logic                     cfg, store, nfil, nrow, fin;
  logic                     unused_eof;

  // end_of_filter is captured alongside end_of_row but sequencing only needs eor
  assign unused_eof = eof_q;
  assign go = io.av_data & io.av_filter & ~io.psum_full;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    rows_d    = rows_q;
    drain_d   = drain_q;
    eor_d     = eor_q;
    eof_d     = eof_q;
    put       = 1'b0;
    cfg       = 1'b0;
    store     = 1'b0;
    nfil      = 1'b0;
    nrow      = 1'b0;
    fin       = 1'b0;
    case (state_q)
      IDLE: if (io.start) begin
        state_d   = CONFIG;
        rows_d    = (io.num_rows == '0) ? ROW_CNT_WIDTH'(1) : io.num_rows;
        row_cnt_d = '0;
      end
      CONFIG: begin
        cfg     = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (go) state_d = COMPUTE;
      COMPUTE: begin
        put = go;
        if (go && io.co_filter) begin
          eor_d   = io.end_of_row;
          eof_d   = io.end_of_filter;
          drain_d = DW'(PIPE_DEPTH - 1);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          store   = 1'b1;
          state_d = eor_q ? ADV_ROW : ADV_FILTER;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ADV_FILTER: begin
        nfil    = 1'b1;
        state_d = WAIT;
      end
      ADV_ROW: begin
        nrow      = 1'b1;
        row_cnt_d = row_cnt_q + ROW_CNT_WIDTH'(1);
        state_d   = (row_cnt_q == rows_q - ROW_CNT_WIDTH'(1)) ? FINISH : WAIT;
      end
      FINISH: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      rows_q    <= '0;
      drain_q   <= '0;
      eor_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      rows_q    <= rows_d;
      drain_q   <= drain_d;
      eor_q     <= eor_d;
      eof_q     <= eof_d;
    end
  end

  assign io.ld_stride    = cfg;
  assign io.ld_fileSize  = cfg;
  assign io.clear_sum    = cfg;
  assign io.put_data     = put;
  assign io.put_filter   = put;
  assign io.store_buffer = store;
  assign io.next_filter  = nfil;
  assign io.next_row     = nrow;
  assign io.done         = fin;
  assign io.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pe_sequencer.sv
// Randomized bench for pe_sequencer; an event-scheduling model predicts every output each cycle.
module tb_pe_sequencer;
  import pe_pkg::*;

  localparam int PD = 3;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_sequencer_if #(.ROW_CNT_WIDTH(RW)) io();

  pe_sequencer #(.PIPE_DEPTH(PD), .ROW_CNT_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .io(io)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  bit mon_en = 0;

  // model: absolute cycle numbers at which each pulse is due (-1 = none)
  bit active = 0, open = 0, adv_row = 0;
  int cfg_at = -1, gate_at = -1, store_at = -1, adv_at = -1, done_at = -1;
  int rows_tot = 0, rows_done = 0;

  // environment: window shaping driven from observed puts
  int win_puts = 0, win_len = 4;
  bit win_eor = 1;
  int nr_cnt = 0, done_cnt = 0, co_cnt = 0, last_co_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    bit go;
    logic [9:0] ov, ev;
    if (mon_en) begin
      go = io.av_data && io.av_filter && !io.psum_full;
      ev = {cyc == cfg_at, cyc == cfg_at, cyc == cfg_at, open && go, open && go,
            cyc == store_at, (cyc == adv_at) && !adv_row, (cyc == adv_at) && adv_row,
            active, cyc == done_at};
      ov = {io.ld_stride, io.ld_fileSize, io.clear_sum, io.put_data, io.put_filter,
            io.store_buffer, io.next_filter, io.next_row, io.busy, io.done};
      check("outs", ov, ev);

      if (io.next_row) nr_cnt++;
      if (io.done) done_cnt++;
      if (io.put_data) begin
        if (io.co_filter) begin
          win_puts = 0;
          win_len = $urandom_range(1, 5);
          win_eor = ($urandom_range(0, 9) < 4);
          co_cnt++;
          last_co_cyc = cyc;
        end else win_puts++;
      end

      if (rst) begin
        active = 0; open = 0;
        cfg_at = -1; gate_at = -1; store_at = -1; adv_at = -1; done_at = -1;
        win_puts = 0;
      end else if (!active) begin
        if (io.start) begin
          active = 1; open = 0;
          cfg_at = cyc + 1; gate_at = cyc + 2;
          rows_tot = (io.num_rows == 0) ? 1 : int'(io.num_rows);
          rows_done = 0;
        end
      end else begin
        if (open && go && io.co_filter) begin
          open = 0;
          store_at = cyc + PD;
          adv_at = cyc + PD + 1;
          adv_row = io.end_of_row;
          if (adv_row) rows_done++;
          if (adv_row && rows_done == rows_tot) done_at = adv_at + 1;
          else gate_at = adv_at + 1;
        end else if (!open && gate_at >= 0 && cyc >= gate_at && go) begin
          open = 1;
          gate_at = -1;
        end
        if (cyc == done_at) active = 0;
      end
      cyc++;
    end
  end

  task automatic drive_rand();
    io.av_data = ($urandom_range(0, 9) < 8);
    io.av_filter = ($urandom_range(0, 9) < 9);
    io.psum_full = ($urandom_range(0, 9) == 0);
    io.co_filter = (win_puts == win_len - 1);
    io.end_of_row = win_eor;
    io.end_of_filter = win_eor | 1'($urandom_range(0, 1));
    io.start = 1'b0;
  endtask

  task automatic run_job(input int rows, input bit rst_mid);
    int d0, r0, c0, k;
    bit got, did_rst;
    d0 = done_cnt; r0 = nr_cnt; c0 = co_cnt; k = 0; got = 0; did_rst = 0;
    @(posedge clk); #1;
    drive_rand();
    io.num_rows = 8'(rows);
    io.start = 1'b1;
    while (k < 30000 && !got) begin
      @(posedge clk); #1;
      drive_rand();
      k++;
      // stray starts while busy: always in FINISH, occasionally elsewhere
      if (active && (done_at == cyc || $urandom_range(0, 15) == 0)) begin
        io.start = 1'b1;
        io.num_rows = 8'($urandom);
      end
      rst = 1'b0;
      if (rst_mid && !did_rst && co_cnt != c0 && cyc == last_co_cyc + 2) begin
        rst = 1'b1;
        did_rst = 1;
      end else if (did_rst) begin
        got = 1;
      end
      if (done_cnt != d0) got = 1;
    end
    check("job_timeout", {31'd0, got}, 32'd1);
    if (rst_mid) begin
      @(posedge clk); #1;
      check("rst_abort_busy", {31'd0, io.busy}, 32'd0);
      check("rst_abort_done", done_cnt - d0, 0);
    end else begin
      check("row_pulses", nr_cnt - r0, (rows == 0) ? 1 : rows);
      check("done_pulses", done_cnt - d0, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    io.num_rows = '0;
    drive_rand();
    io.start = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;
    drive_rand();
    io.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_rand();
    repeat (2) begin @(posedge clk); #1; drive_rand(); end
    check("idle_busy", {31'd0, io.busy}, 32'd0);

    run_job(1, 0);
    run_job(2, 0);
    run_job(0, 0);
    run_job(3, 1);
    run_job(1, 0);
    repeat (4) run_job($urandom_range(1, 4), 0);
    run_job(255, 0);

    repeat (4) begin @(posedge clk); #1; drive_rand(); end
    check("final_busy", {31'd0, io.busy}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_sequencer.md
Name: pe_sequencer

Overview:
- Control FSM for the convolution PE datapath. It drives ld_stride, ld_fileSize, put_data, put_filter, clear_sum, store_buffer, next_filter and next_row, and consumes av_data, av_filter, co_filter, end_of_row and end_of_filter.
- It runs one full job (config, windows, rows), handles stalls from empty input FIFOs or a full Psum buffer, and drains the 3-stage MAC pipeline before advancing the filter or row.
- It sits beside the datapath inside the PE wrapper.

Parameters:
- PIPE_DEPTH, 3: MAC pipeline stages between put_data and Psum write; sets drain length.
- ROW_CNT_WIDTH, 8: width of the row counter and of num_rows.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  job start pulse; honoured only in IDLE
- num_rows  in  ROW_CNT_WIDTH  output rows per job; latched on accepted start; 0 is treated as 1
- av_data  in  1  IFMap window element available
- av_filter  in  1  filter element available
- co_filter  in  1  current filter window complete (last element issued this cycle)
- end_of_row  in  1  IFMap row exhausted
- end_of_filter  in  1  last filter position of row
- psum_full  in  1  Psum FIFO full (backpressure)
- ld_stride  out  1  load stride register
- ld_fileSize  out  1  load filter-size register
- put_data  out  1  issue IFMap element into pipeline
- put_filter  out  1  issue filter element into pipeline
- clear_sum  out  1  clear accumulator/FIFOs
- store_buffer  out  1  commit finished Psum
- next_filter  out  1  advance filter pointer
- next_row  out  1  advance IFMap row
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle job-complete pulse

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high. Reset is sampled every cycle, including mid-job: state goes to IDLE, row_cnt=0, drain_cnt=0, latched flags=0, and all outputs are 0 on the cycle after rst is sampled high.
- Outputs are decoded from state (Moore), except put_data/put_filter, which are Mealy-gated as described under COMPUTE.
- States: IDLE, CONFIG, WAIT, COMPUTE, DRAIN, ADV_FILTER, ADV_ROW, FINISH.
- IDLE: all outputs 0. On start=1: go to CONFIG, latch num_rows (0 becomes 1), row_cnt=0.
- CONFIG (exactly 1 cycle): ld_stride=ld_fileSize=clear_sum=1. Next state WAIT.
- WAIT: go = av_data & av_filter & !psum_full. If go, next state COMPUTE; no put is issued in WAIT.
- COMPUTE: put_data = put_filter = go (same cycle, always equal).
  - If go=0: stay in COMPUTE and issue nothing (stall bubble).
  - If co_filter=1 while go=1: latch eor=end_of_row and eof=end_of_filter, set drain_cnt=PIPE_DEPTH-1, next state DRAIN.
  - co_filter while go=0 is ignored.
- DRAIN: no puts. drain_cnt decrements each cycle. store_buffer=1 only on the cycle drain_cnt==0. Next state:
  - ADV_ROW if eor, else
  - ADV_FILTER.
- ADV_FILTER (1 cycle): next_filter=1. Next state WAIT.
- ADV_ROW (1 cycle): next_row=1 and row_cnt+1.
  - If row_cnt == rows_latched-1 before the increment: next state FINISH.
  - Else: next state WAIT.
- FINISH (1 cycle): done=1. Next state IDLE.
- Latency from the last co_filter put to store_buffer: exactly PIPE_DEPTH cycles.
- next_filter, next_row, store_buffer, ld_* and done are each strictly single-cycle pulses, never simultaneous with put_*.
- start outside IDLE is ignored. start in the same cycle as rst: reset wins.
- psum_full rising during COMPUTE stalls puts on that same cycle. DRAIN is not blocked by psum_full (the FIFO depth covers PIPE_DEPTH).
- row_cnt wraps modulo 2^ROW_CNT_WIDTH; rows_latched max is 2^ROW_CNT_WIDTH-1.

Decomposition:
- Shared package pe_pkg:
  - state_e enum (IDLE..FINISH, 3-bit)
  - localparam DRAIN_W = $clog2(PIPE_DEPTH)+1
- No sub-module. A single FSM with next-state/output combinational blocks and one registered always block; drain and row counters are inline.

Test Plan:
- Basic job: rst 2 cycles, start with num_rows=1, av_*=1, co_filter on the 4th put with end_of_row=1 → ld_stride/ld_fileSize/clear_sum at cycle 1, 4 puts, store_buffer exactly 3 cycles after the last put, then next_row, then done (1 cycle); busy back to 0.
- Stall: drop av_data for 2 cycles mid-window, then raise psum_full for 1 cycle → put_data=put_filter=0 for exactly those 3 cycles; total puts still 4; co_filter during a stall cycle is ignored.
- Multi-filter row: num_rows=2, co_filter with end_of_row=0 twice, then =1 → next_filter pulses twice, next_row once, row_cnt=1, no done; second row completes → done.
- Reset mid-DRAIN: assert rst when drain_cnt=1 → the following cycle has all outputs 0, busy=0, and no store_buffer is emitted.
- start in non-IDLE: pulse start during COMPUTE and during FINISH → no extra CONFIG pulses; num_rows=0 job → behaves as 1 row.
- Boundary: num_rows=255 (ROW_CNT_WIDTH=8) → exactly 255 next_row pulses, then done, then return to IDLE.
